// File: rtl/uio_bus_arbiter_if.sv
// Bundle of the arbiter's requester-side and uio pad-side signals.
// The arbiter takes the slave view; whatever drives requests and pads takes the master view.
interface uio_bus_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic                  ena;
    logic [NREQ-1:0]       req_i;
    logic [NREQ-1:0]       last_i;
    logic [8*NREQ-1:0]     wdata_i;
    logic [8*NREQ-1:0]     dir_i;
    logic [7:0]            uio_in;
    logic [7:0]            uio_out;
    logic [7:0]            uio_oe;
    logic [NREQ-1:0]       gnt_o;
    logic [7:0]            rdata_o;
    logic                  rvalid_o;
    logic                  timeout_o;
    logic                  busy_o;

    modport slave (
        input  ena, req_i, last_i, wdata_i, dir_i, uio_in,
        output uio_out, uio_oe, gnt_o, rdata_o, rvalid_o, timeout_o, busy_o
    );

    modport master (
        output ena, req_i, last_i, wdata_i, dir_i, uio_in,
        input  uio_out, uio_oe, gnt_o, rdata_o, rvalid_o, timeout_o, busy_o
    );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pins with hold timeout and a bus-turnaround gap
// between owners so that two drivers never overlap on the pads.
module uio_bus_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned MAX_HOLD    = 16,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    uio_bus_arbiter_if.slave bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned HW = $clog2(MAX_HOLD);
    localparam int unsigned TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t            state, state_next;
    logic [NREQ-1:0]   gnt, gnt_next;
    logic [PW-1:0]     owner, owner_next;
    logic [PW-1:0]     ptr, ptr_next;
    logic [HW-1:0]     hold, hold_next;
    logic [TW-1:0]     turn, turn_next;
    logic              timeout_next;
    logic              found;
    logic [PW-1:0]     winner;
    logic [PW-1:0]     cand;
    logic              req_own, last_own;
    logic [7:0]        wdata_own, dir_own;

    assign req_own   = bus.req_i[owner];
    assign last_own  = bus.last_i[owner];
    assign wdata_own = bus.wdata_i[{owner, 3'b000} +: 8];
    assign dir_own   = bus.dir_i[{owner, 3'b000} +: 8];

    // First request at or after the pointer, wrapping past NREQ-1 back to 0.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(ptr) + i >= NREQ) ? PW'(32'(ptr) + i - NREQ) : PW'(32'(ptr) + i);
            if (!found && bus.req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_next   = state;
        gnt_next     = gnt;
        owner_next   = owner;
        ptr_next     = ptr;
        hold_next    = hold;
        turn_next    = turn;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ena && found) begin
                    state_next = OWN;
                    gnt_next   = NREQ'(1) << winner;
                    owner_next = winner;
                    hold_next  = '0;
                    ptr_next   = (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
                end
            end
            OWN: begin
                hold_next = hold + HW'(1);
                if (!bus.ena) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                end else if (!req_own || last_own || hold == HW'(MAX_HOLD - 1)) begin
                    state_next   = TURN;
                    gnt_next     = '0;
                    turn_next    = '0;
                    // Only the hold limit can release a still-requesting, non-final owner.
                    timeout_next = req_own && !last_own;
                end
            end
            TURN: begin
                if (turn == TW'(TURN_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    turn_next = turn + TW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            gnt           <= '0;
            owner         <= '0;
            ptr           <= '0;
            hold          <= '0;
            turn          <= '0;
            bus.timeout_o <= 1'b0;
            bus.rdata_o   <= '0;
            bus.rvalid_o  <= 1'b0;
        end else begin
            state         <= state_next;
            gnt           <= gnt_next;
            owner         <= owner_next;
            ptr           <= ptr_next;
            hold          <= hold_next;
            turn          <= turn_next;
            bus.timeout_o <= timeout_next;
            bus.rvalid_o  <= (state == OWN);
            if (state == OWN) begin
                bus.rdata_o <= bus.uio_in;
            end
        end
    end

    // Pad drive is combinational from the owner but gated by state, so async reset drops it at once.
    always_comb begin
        bus.uio_oe  = '0;
        bus.uio_out = '0;
        if (state == OWN && bus.ena) begin
            bus.uio_oe  = dir_own;
            bus.uio_out = wdata_own & dir_own;
        end
    end

    assign bus.gnt_o  = gnt;
    assign bus.busy_o = (state != IDLE);
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Randomized bench for uio_bus_arbiter against an integer-level reference model of
// round-robin ownership, hold limit and turnaround.
module tb_uio_bus_arbiter;
    localparam int unsigned NREQ        = 4;
    localparam int unsigned MAX_HOLD    = 16;
    localparam int unsigned TURN_CYCLES = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uio_bus_arbiter_if #(.NREQ(NREQ)) bus ();

    uio_bus_arbiter #(
        .NREQ       (NREQ),
        .MAX_HOLD   (MAX_HOLD),
        .TURN_CYCLES(TURN_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the bus, how many cycles it has owned, cycles of gap left.
    bit       m_own;
    int       m_owner;
    int       m_held;
    int       m_gap;
    int       m_ptr;
    bit       m_rvalid;
    bit       m_timeout;
    bit [7:0] m_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own     = 1'b0;
        m_owner   = 0;
        m_held    = 0;
        m_gap     = 0;
        m_ptr     = 0;
        m_rvalid  = 1'b0;
        m_timeout = 1'b0;
        m_rdata   = 8'h00;
    endtask

    task automatic check_all();
        logic [31:0] exp_gnt;
        logic [7:0]  exp_oe;
        logic [7:0]  exp_out;
        logic [7:0]  d;
        logic [7:0]  w;
        exp_gnt = m_own ? (32'd1 << m_owner) : 32'd0;
        exp_oe  = 8'h00;
        exp_out = 8'h00;
        if (m_own && bus.ena) begin
            d       = bus.dir_i[m_owner*8 +: 8];
            w       = bus.wdata_i[m_owner*8 +: 8];
            exp_oe  = d;
            exp_out = w & d;
        end
        check("gnt",     bus.gnt_o,     exp_gnt);
        check("uio_oe",  bus.uio_oe,    exp_oe);
        check("uio_out", bus.uio_out,   exp_out);
        check("rvalid",  bus.rvalid_o,  m_rvalid);
        check("rdata",   bus.rdata_o,   m_rdata);
        check("timeout", bus.timeout_o, m_timeout);
        check("busy",    bus.busy_o,    m_own || (m_gap > 0));
    endtask

    task automatic model_step();
        bit was_own;
        was_own   = m_own;
        m_timeout = 1'b0;
        if (was_own) begin
            m_rdata = bus.uio_in;
        end
        m_rvalid = was_own;
        if (was_own) begin
            m_held++;
            if (!bus.ena) begin
                m_own = 1'b0;
                m_gap = 0;
            end else if (!bus.req_i[m_owner] || bus.last_i[m_owner]) begin
                m_own = 1'b0;
                m_gap = TURN_CYCLES;
            end else if (m_held == MAX_HOLD) begin
                m_own     = 1'b0;
                m_gap     = TURN_CYCLES;
                m_timeout = 1'b1;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (bus.ena && bus.req_i != '0) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (bus.req_i[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
            end
            m_own  = 1'b1;
            m_held = 0;
            m_ptr  = (m_owner + 1) % NREQ;
        end
    endtask

    // Entered at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic run_cycle();
        #1;
        check_all();
        model_step();
        @(negedge clk);
    endtask

    task automatic drive_rand(input bit hold_heavy);
        bus.ena = ($urandom_range(0, 49) != 0);
        for (int k = 0; k < NREQ; k++) begin
            if (hold_heavy) bus.req_i[k] = ($urandom_range(0, 5) != 0);
            else if ($urandom_range(0, 5) == 0) bus.req_i[k] = ~bus.req_i[k];
            bus.last_i[k] = hold_heavy ? 1'b0 : ($urandom_range(0, 5) == 0);
            bus.wdata_i[k*8 +: 8] = 8'($urandom);
            bus.dir_i[k*8 +: 8]   = 8'($urandom);
        end
        bus.uio_in = 8'($urandom);
    endtask

    initial begin
        bus.ena     = 1'b0;
        bus.req_i   = '0;
        bus.last_i  = '0;
        bus.wdata_i = '0;
        bus.dir_i   = '0;
        bus.uio_in  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // req 0101 from reset: requester 0 first, then requester 2 after a turnaround.
        bus.ena     = 1'b1;
        bus.req_i   = 4'b0101;
        bus.wdata_i = 32'h3C_77_5A_C3;
        bus.dir_i   = 32'h0F_FF_00_F0;
        bus.uio_in  = 8'hA5;
        run_cycle();
        check("plan_gnt0", bus.gnt_o, 32'h1);
        check("plan_oe0", bus.uio_oe, 32'hF0);
        check("plan_out0", bus.uio_out, 32'hC0);
        run_cycle();
        check("plan_rdata", bus.rdata_o, 32'hA5);
        run_cycle();
        bus.last_i = 4'b0001;
        run_cycle();
        bus.last_i = 4'b0000;
        check("plan_turn_gnt", bus.gnt_o, 32'h0);
        check("plan_turn_oe", bus.uio_oe, 32'h0);
        run_cycle();
        run_cycle();
        check("plan_gnt2", bus.gnt_o, 32'h4);

        for (int c = 0; c < 1500; c++) begin
            drive_rand(1'b0);
            run_cycle();
        end
        for (int c = 0; c < 1200; c++) begin
            drive_rand(1'b1);
            run_cycle();
        end

        // Asynchronous reset in the middle of ownership.
        bus.ena    = 1'b1;
        bus.req_i  = 4'b1111;
        bus.last_i = 4'b0000;
        bus.dir_i  = '1;
        for (int c = 0; c < 8 && !m_own; c++) run_cycle();
        check("pre_reset_own", bus.gnt_o != '0, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_oe", bus.uio_oe, 32'h0);
        check("areset_gnt", bus.gnt_o, 32'h0);
        check("areset_busy", bus.busy_o, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle();
        check("post_reset_gnt", bus.gnt_o, 32'h1);
        repeat (4) run_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uio_bus_arbiter.md
Name: uio_bus_arbiter

Overview:
- Shares the 8 bidirectional uio pins of the top-level tt_um_DigitalLogicLab2 between NREQ internal requesters.
- Grants are round-robin. The owner drives uio_out/uio_oe. A bus-turnaround gap separates successive owners so no two drivers ever overlap.
- A hold timeout stops any one requester from starving the others.
- Sits directly between the internal datapath blocks and the uio_* top-level ports.

Parameters:
- NREQ, 4, number of requesters (2..8); index 0 is highest priority at reset.
- MAX_HOLD, 16, maximum consecutive owned cycles before a forced release (>=2).
- TURN_CYCLES, 1, idle cycles with uio_oe=0 after every release (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design-selected enable; 0 forces a release and holds IDLE
- req_i  in  NREQ  per-requester bus request, level
- last_i  in  NREQ  owner's final beat this cycle; valid only with req_i
- wdata_i  in  8*NREQ  per-requester output data, requester k at [8k+7:8k]
- dir_i  in  8*NREQ  per-requester pin-drive mask, 1 = drive pin
- uio_in  in  8  pad input path
- uio_out  out  8  pad output path
- uio_oe  out  8  pad output enable
- gnt_o  out  NREQ  one-hot grant, registered
- rdata_o  out  8  registered uio_in sampled during ownership
- rvalid_o  out  1  rdata_o valid pulse
- timeout_o  out  1  one-cycle pulse on forced release
- busy_o  out  1  state != IDLE

Behaviour:
- Reset values, all asynchronous: state=IDLE; gnt_o=0; uio_out=0; uio_oe=0; rdata_o=0; rvalid_o=0; timeout_o=0; hold counter=0; turn counter=0; priority pointer=0.
- States: IDLE, OWN, TURN.
- IDLE:
  - If ena=1 and any req_i bit is set, pick the winner by round-robin: the first set bit at or after the pointer, wrapping at NREQ-1 -> 0.
  - Next cycle: state=OWN, gnt_o=onehot(winner), hold counter=0, pointer=(winner+1) mod NREQ.
  - Grant latency is 1 cycle from req_i seen in IDLE.
- OWN:
  - uio_out = wdata_i[owner] & dir_i[owner], combinational.
  - uio_oe = dir_i[owner], combinational.
  - The hold counter increments every OWN cycle.
- Release from OWN: state goes to TURN the next cycle and gnt_o clears. Release is triggered when any of these hold:
  - (a) req_i[owner]=0; that cycle is not a beat.
  - (b) req_i[owner]=1 and last_i[owner]=1; that cycle is a completed beat.
  - (c) the hold counter reaches MAX_HOLD-1; timeout_o pulses on the cycle state enters TURN.
  - (d) ena=0; state goes to IDLE rather than TURN, and no turnaround is applied because oe is already forced 0.
- If (b) and (c) occur in the same cycle, treat it as a normal completion: no timeout pulse.
- TURN:
  - uio_oe=0, uio_out=0, gnt_o=0.
  - Stays for exactly TURN_CYCLES cycles, then goes to IDLE.
  - Requests seen during TURN are ignored; they are re-evaluated in IDLE.
- Outside OWN: uio_oe=0 and uio_out=0 always, in every state, and whenever ena=0.
- rdata_o/rvalid_o:
  - On every OWN cycle, rdata_o <= uio_in and rvalid_o <= 1 on the next edge. Otherwise rvalid_o <= 0 and rdata_o holds.
- Minimum gap between two grants is TURN_CYCLES+1 cycles.
- A requester that dropped req_i and re-asserts it competes normally. The pointer guarantees every other active requester is served first.
- The pointer is retained across ena=0; only rst_n clears it.
- Reset mid-OWN: uio_oe drops to 0 immediately (asynchronous) and gnt_o clears.

Test Plan:
- Reset, then req_i=4'b0101 in IDLE -> gnt_o=0001 one cycle later; uio_oe=dir_i[0], uio_out=wdata_i[0]&dir_i[0]; pointer=1.
- Requester 0 asserts last_i on its 3rd OWN cycle with req_i still 0101 -> gnt_o=0 for 1 TURN cycle (uio_oe=00), then IDLE, then gnt_o=0100.
- Requester 1 holds req_i=1 and never asserts last_i, MAX_HOLD=16 -> exactly 16 OWN cycles, timeout_o pulses once, TURN 1 cycle; with req_i=0011 the next grant is 0001 (wrap).
- dir_i[owner]=8'hF0 with uio_in=8'hA5 driven in OWN -> rvalid_o high every OWN cycle (lagging 1), rdata_o=A5, uio_oe=F0.
- ena dropped mid-OWN -> next cycle IDLE, gnt_o=0, uio_oe=0, no timeout_o; ena re-raised -> grant resumes from the retained pointer.
- rst_n pulsed low mid-OWN, asynchronous to clk -> uio_oe=0 and gnt_o=0 before the next edge; pointer=0 afterwards, so req_i=1111 grants 0001.
